parking_gate_sequencer: RTL and testbench
=========================================

Name: parking_gate_sequencer

Overview:
- Single-lane, bidirectional barrier-gate controller for the smart parking system.
- Consumes three debounced sensor levels, each from its own Debouncer instance: entry approach loop, exit approach loop, and under-gate loop.
- Arbitrates entry vs exit requests for the one shared gate, sequences open/pass/hold/close, and maintains the occupancy count against lot capacity.

Parameters:
- CAPACITY, 8: maximum cars; entry refused when occupancy equals CAPACITY.
- OCC_W, 4: occupancy width; must satisfy 2^OCC_W > CAPACITY.
- TIMEOUT_CYCLES, 200: cycles the gate waits in an OPEN state for a car to reach the under-gate loop.
- HOLD_CYCLES, 40: cycles the gate stays open after a car clears the under-gate loop.
- TIMER_W, 16: timer width; must hold max(TIMEOUT_CYCLES, HOLD_CYCLES).

Ports:
- clk  in  1  system clock (40 MHz)
- reset  in  1  synchronous, active-high reset
- entry_sensor  in  1  debounced, car waiting at entry loop
- exit_sensor  in  1  debounced, car waiting at exit loop
- gate_sensor  in  1  debounced, car under gate
- gate_open  out  1  barrier drive; 1 = raised
- occupancy  out  OCC_W  cars currently inside
- full  out  1  occupancy == CAPACITY
- car_in  out  1  one-cycle pulse on completed entry
- car_out  out  1  one-cycle pulse on completed exit
- timeout  out  1  one-cycle pulse on aborted open
- state  out  3  debug state code: IDLE=0, OPEN_IN=1, PASS_IN=2, OPEN_OUT=3, PASS_OUT=4, HOLD=5

Behaviour:
- Reset (sampled on clk edge): state=IDLE, timer=0, occupancy=0, gate_open=0, full=0, all pulses 0. Mid-operation reset closes the gate on that same edge and clears the count.
- All outputs are registered. gate_open=1 in OPEN_IN, PASS_IN, OPEN_OUT, PASS_OUT and HOLD. full is updated on the same edge as occupancy.
- IDLE:
  - exit_sensor=1 → OPEN_OUT. Exit has priority over a simultaneous entry.
  - else entry_sensor=1 and full=0 → OPEN_IN.
  - entry_sensor=1 with full=1 is ignored; stay IDLE.
  - Requests are level-sensitive; nothing is latched while not IDLE.
  - Latency: request sampled at edge N → gate_open=1 after edge N.
- OPEN_IN / OPEN_OUT:
  - timer clears on entry and increments each cycle.
  - gate_sensor=1 → PASS_IN / PASS_OUT.
  - else timer==TIMEOUT_CYCLES-1 → IDLE, timeout=1 for one cycle, gate_open=0, occupancy unchanged.
- PASS_IN / PASS_OUT:
  - No timeout; the gate never closes on a car.
  - gate_sensor=0 → HOLD, with occupancy updated on that edge.
  - PASS_IN: occupancy+1 and car_in=1.
  - PASS_OUT: occupancy-1 and car_out=1 when occupancy>0. At occupancy 0 it saturates at 0, still pulses car_out and still goes to HOLD.
  - Entry increment cannot exceed CAPACITY because entry is gated by full. Increment still saturates at CAPACITY defensively.
- HOLD:
  - timer clears on entry.
  - gate_sensor=1 clears timer and stays in HOLD (safety restart).
  - timer==HOLD_CYCLES-1 with gate_sensor=0 → IDLE, gate_open=0 after that edge.
- Only one of car_in/car_out/timeout can pulse per cycle. Undefined state codes → IDLE.

Test Plan:
- Reset, then entry_sensor=1 for 3 cycles → gate_open=1 one edge later, state=1; gate_sensor 1 for 10 cycles then 0 → car_in pulse, occupancy=1, state=5; after 40 cycles gate_open=0, state=0.
- CAPACITY=3: three full entry sequences → occupancy=3, full=1; fourth entry_sensor=1 for 50 cycles → gate_open stays 0, state stays 0.
- entry_sensor and exit_sensor both rise on the same edge with occupancy=2 → state=3 (OPEN_OUT); completion gives car_out, occupancy=1.
- entry_sensor pulse, gate_sensor never asserts → timeout pulse exactly 200 cycles after state=1, gate_open=0, occupancy unchanged.
- During HOLD, gate_sensor=1 at hold cycle 30 for 5 cycles → gate stays open; closes 40 cycles after gate_sensor falls.
- Reset asserted in PASS_IN with occupancy=2 → next edge gate_open=0, occupancy=0, state=0, no car_in pulse.

Source files
------------

// File: rtl/parking_gate_sequencer.sv
// Single-lane bidirectional barrier-gate controller.
// Arbitrates entry/exit requests for one shared gate, sequences
// open -> pass -> hold -> close, and tracks lot occupancy against capacity.
module parking_gate_sequencer #(
  parameter int unsigned CAPACITY       = 8,
  parameter int unsigned OCC_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 200,
  parameter int unsigned HOLD_CYCLES    = 40,
  parameter int unsigned TIMER_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_sensor,
  input  logic             exit_sensor,
  input  logic             gate_sensor,
  output logic             gate_open,
  output logic [OCC_W-1:0] occupancy,
  output logic             full,
  output logic             car_in,
  output logic             car_out,
  output logic             timeout,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    OPEN_IN  = 3'd1,
    PASS_IN  = 3'd2,
    OPEN_OUT = 3'd3,
    PASS_OUT = 3'd4,
    HOLD     = 3'd5
  } state_t;

  localparam logic [OCC_W-1:0]   CAP_VAL      = OCC_W'(CAPACITY);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_LAST    = TIMER_W'(HOLD_CYCLES - 1);

  state_t             state_q;
  logic [TIMER_W-1:0] timer;
  logic [OCC_W-1:0]   occ_inc;
  logic [OCC_W-1:0]   occ_dec;

  assign state = state_q;

  // Saturating next-occupancy candidates for a completed entry or exit.
  always_comb begin
    occ_inc = occupancy;
    occ_dec = occupancy;
    if (occupancy != CAP_VAL) occ_inc = occupancy + 1'b1;
    if (occupancy != '0)      occ_dec = occupancy - 1'b1;
  end

  // Gate sequencer: state, timer, occupancy and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      timer     <= '0;
      occupancy <= '0;
      gate_open <= 1'b0;
      full      <= 1'b0;
      car_in    <= 1'b0;
      car_out   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      car_in  <= 1'b0;
      car_out <= 1'b0;
      timeout <= 1'b0;
      case (state_q)
        IDLE: begin
          timer <= '0;
          if (exit_sensor) begin
            state_q   <= OPEN_OUT;
            gate_open <= 1'b1;
          end else if (entry_sensor && !full) begin
            state_q   <= OPEN_IN;
            gate_open <= 1'b1;
          end
        end
        OPEN_IN, OPEN_OUT: begin
          if (gate_sensor) begin
            state_q <= (state_q == OPEN_IN) ? PASS_IN : PASS_OUT;
            timer   <= '0;
          end else if (timer == TIMEOUT_LAST) begin
            state_q   <= IDLE;
            timer     <= '0;
            gate_open <= 1'b0;
            timeout   <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        PASS_IN: begin
          if (!gate_sensor) begin
            state_q   <= HOLD;
            timer     <= '0;
            occupancy <= occ_inc;
            full      <= (occ_inc == CAP_VAL);
            car_in    <= 1'b1;
          end
        end
        PASS_OUT: begin
          if (!gate_sensor) begin
            state_q   <= HOLD;
            timer     <= '0;
            occupancy <= occ_dec;
            full      <= (occ_dec == CAP_VAL);
            car_out   <= 1'b1;
          end
        end
        HOLD: begin
          if (gate_sensor) begin
            timer <= '0;
          end else if (timer == HOLD_LAST) begin
            state_q   <= IDLE;
            timer     <= '0;
            gate_open <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          timer     <= '0;
          gate_open <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parking_gate_sequencer.sv
// Scoreboard bench for parking_gate_sequencer (CAPACITY=3).
// Stimulus pushes hand-computed output events; a negedge monitor pops and
// compares whenever the gate changes or a pulse appears.
module tb_parking_gate_sequencer;

  localparam int CAP = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_sensor;
  logic       exit_sensor;
  logic       gate_sensor;
  logic       gate_open;
  logic [3:0] occupancy;
  logic       full;
  logic       car_in;
  logic       car_out;
  logic       timeout;
  logic [2:0] state;

  typedef struct {
    int         cyc;
    logic       gate;
    logic [2:0] st;
    logic [3:0] occ;
    logic       full;
    logic       ci;
    logic       co;
    logic       to;
  } ev_t;

  ev_t  exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic mon_en = 1'b0;
  logic prev_gate = 1'b0;

  parking_gate_sequencer #(
    .CAPACITY(CAP),
    .OCC_W(4),
    .TIMEOUT_CYCLES(200),
    .HOLD_CYCLES(40),
    .TIMER_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .entry_sensor(entry_sensor),
    .exit_sensor(exit_sensor),
    .gate_sensor(gate_sensor),
    .gate_open(gate_open),
    .occupancy(occupancy),
    .full(full),
    .car_in(car_in),
    .car_out(car_out),
    .timeout(timeout),
    .state(state)
  );

  always #5 clk = ~clk;

  // Edge counter used to timestamp expected and observed events.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any gate change or pulse is an event to be matched in order.
  always @(negedge clk) begin
    if (mon_en && (gate_open !== prev_gate || car_in || car_out || timeout)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d gate=%0b state=%0d occ=%0d ci=%0b co=%0b to=%0b required=no event",
                 cyc, gate_open, state, occupancy, car_in, car_out, timeout);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (cyc != e.cyc || gate_open !== e.gate || state !== e.st || occupancy !== e.occ ||
            full !== e.full || car_in !== e.ci || car_out !== e.co || timeout !== e.to) begin
          failures++;
          $display("FAIL event actual: cyc=%0d gate=%0b state=%0d occ=%0d full=%0b ci=%0b co=%0b to=%0b required: cyc=%0d gate=%0b state=%0d occ=%0d full=%0b ci=%0b co=%0b to=%0b",
                   cyc, gate_open, state, occupancy, full, car_in, car_out, timeout,
                   e.cyc, e.gate, e.st, e.occ, e.full, e.ci, e.co, e.to);
        end
      end
    end
    prev_gate = gate_open;
  end

  function automatic ev_t mk(input int c, input logic g, input int st, input int occ,
                             input logic ci, input logic co, input logic to);
    ev_t e;
    e.cyc  = c;
    e.gate = g;
    e.st   = 3'(st);
    e.occ  = 4'(occ);
    e.full = (occ == CAP);
    e.ci   = ci;
    e.co   = co;
    e.to   = to;
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One complete passage: request for 3 cycles, car under gate for 10, hold 40.
  task automatic car_pass(input bit use_entry, input bit use_exit, input int occ_before);
    int c;
    bit is_entry;
    int occ_after;
    is_entry  = use_entry && !use_exit;
    occ_after = is_entry ? ((occ_before < CAP) ? occ_before + 1 : CAP)
                         : ((occ_before > 0) ? occ_before - 1 : 0);
    c = cyc;
    entry_sensor = use_entry;
    exit_sensor  = use_exit;
    exp_q.push_back(mk(c + 1, 1'b1, is_entry ? 1 : 3, occ_before, 1'b0, 1'b0, 1'b0));
    tick(3);
    entry_sensor = 1'b0;
    exit_sensor  = 1'b0;
    gate_sensor  = 1'b1;
    tick(10);
    gate_sensor = 1'b0;
    exp_q.push_back(mk(c + 14, 1'b1, 5, occ_after, is_entry, !is_entry, 1'b0));
    exp_q.push_back(mk(c + 54, 1'b0, 0, occ_after, 1'b0, 1'b0, 1'b0));
    tick(46);
  endtask

  initial begin
    int  c;
    bit  bad;
    reset        = 1'b1;
    entry_sensor = 1'b0;
    exit_sensor  = 1'b0;
    gate_sensor  = 1'b0;
    tick(3);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (gate_open !== 1'b0 || state !== 3'd0 || occupancy !== 4'd0 || full !== 1'b0 ||
        car_in !== 1'b0 || car_out !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_state actual gate=%0b state=%0d occ=%0d full=%0b pulses=%0b%0b%0b required all zero",
               gate_open, state, occupancy, full, car_in, car_out, timeout);
    end
    mon_en = 1'b1;
    tick(2);

    // Three entries fill the lot.
    car_pass(1'b1, 1'b0, 0);
    car_pass(1'b1, 1'b0, 1);
    car_pass(1'b1, 1'b0, 2);

    // Entry request while full is ignored for 50 cycles.
    entry_sensor = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (gate_open !== 1'b0 || state !== 3'd0 || full !== 1'b1) bad = 1'b1;
    end
    entry_sensor = 1'b0;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL refuse_when_full actual gate=%0b state=%0d full=%0b required gate=0 state=0 full=1",
               gate_open, state, full);
    end
    tick(2);

    // Exit alone (3 -> 2), then simultaneous entry+exit: exit wins (2 -> 1).
    car_pass(1'b0, 1'b1, 3);
    car_pass(1'b1, 1'b1, 2);

    // Entry pulse with no car under the gate: timeout 200 cycles after opening.
    c = cyc;
    entry_sensor = 1'b1;
    exp_q.push_back(mk(c + 1, 1'b1, 1, 1, 1'b0, 1'b0, 1'b0));
    tick(1);
    entry_sensor = 1'b0;
    exp_q.push_back(mk(c + 201, 1'b0, 0, 1, 1'b0, 1'b0, 1'b1));
    tick(210);

    // HOLD restart: car returns under the gate at hold cycle 30 for 5 cycles.
    c = cyc;
    entry_sensor = 1'b1;
    exp_q.push_back(mk(c + 1, 1'b1, 1, 1, 1'b0, 1'b0, 1'b0));
    tick(3);
    entry_sensor = 1'b0;
    gate_sensor  = 1'b1;
    tick(10);
    gate_sensor = 1'b0;
    exp_q.push_back(mk(c + 14, 1'b1, 5, 2, 1'b1, 1'b0, 1'b0));
    tick(30);
    gate_sensor = 1'b1;
    tick(5);
    gate_sensor = 1'b0;
    exp_q.push_back(mk(c + 88, 1'b0, 0, 2, 1'b0, 1'b0, 1'b0));
    tick(50);

    // Reset while in PASS_IN at occupancy 2: gate closes, count clears, no car_in.
    c = cyc;
    entry_sensor = 1'b1;
    exp_q.push_back(mk(c + 1, 1'b1, 1, 2, 1'b0, 1'b0, 1'b0));
    tick(3);
    entry_sensor = 1'b0;
    gate_sensor  = 1'b1;
    tick(5);
    reset       = 1'b1;
    gate_sensor = 1'b0;
    exp_q.push_back(mk(c + 9, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0));
    tick(1);
    reset = 1'b0;
    tick(10);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL events_drained actual pending=%0d required pending=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=time limit reached required=bench completion");
    $fatal(1, "watchdog");
  end

endmodule
